// File: rtl/i2c_xlate_map_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_xlate_map_ctrl
//
// Controller and configuration store for the I2C address translator.
// Holds ENTRIES mappings (virtual 7-bit address -> physical address + port).
// The translator resolves captured addresses through a lookup. A host or
// config engine programs the table. Lookups always win arbitration.
//
// Ports
//   SCL          clock, rising edge (shared with the translator)
//   rst_n        asynchronous active-low reset
//   lk_req       lookup request, held high until lk_done
//   lk_vaddr     virtual address to resolve, stable while lk_req is high
//   lk_done      one-cycle pulse: lk_hit/lk_paddr/lk_port are valid
//   lk_hit       an enabled matching entry was found
//   lk_paddr     physical address (0 on miss)
//   lk_port      downstream port, 0=SDA1 side, 1=SDA2 side (0 on miss)
//   cfg_wr_valid config write request
//   cfg_wr_ready config write may be accepted this cycle (combinational)
//   cfg_idx      entry to write
//   cfg_vaddr    virtual address to store
//   cfg_paddr    physical address to store
//   cfg_port     port select to store
//   cfg_en       entry enable to store
//   cfg_err      one-cycle pulse: the last accepted write was ignored or
//                forced disabled
//   busy         controller is scanning or concluding a lookup
//   dbg_state    current FSM state (IDLE=0, SCAN=1, DONE=2)
//
// Config handshake: a write transfers on a rising edge where both
// cfg_wr_valid and cfg_wr_ready are high. cfg_wr_ready is only high in IDLE
// with no lookup request, so the write lands in the table on that edge and
// is visible to every lookup whose request is sampled afterwards.
// ---------------------------------------------------------------------------
module i2c_xlate_map_ctrl #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2,
  parameter int ADDR_W  = 7
) (
  input  logic              SCL,
  input  logic              rst_n,
  input  logic              lk_req,
  input  logic [ADDR_W-1:0] lk_vaddr,
  output logic              lk_done,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_paddr,
  output logic              lk_port,
  input  logic              cfg_wr_valid,
  output logic              cfg_wr_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_vaddr,
  input  logic [ADDR_W-1:0] cfg_paddr,
  input  logic              cfg_port,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic              lk_done_q, lk_done_d;
  logic              lk_hit_q, lk_hit_d;
  logic [ADDR_W-1:0] lk_paddr_q, lk_paddr_d;
  logic              lk_port_q, lk_port_d;
  logic              cfg_err_q, cfg_err_d;

  logic [ADDR_W-1:0] tbl_vaddr_q [ENTRIES];
  logic [ADDR_W-1:0] tbl_vaddr_d [ENTRIES];
  logic [ADDR_W-1:0] tbl_paddr_q [ENTRIES];
  logic [ADDR_W-1:0] tbl_paddr_d [ENTRIES];
  logic              tbl_port_q  [ENTRIES];
  logic              tbl_port_d  [ENTRIES];
  logic              tbl_en_q    [ENTRIES];
  logic              tbl_en_d    [ENTRIES];

  // Entry currently addressed by the scan, and range check of cfg_idx.
  // Both are explicit compare-and-select so that index widths wider than
  // the table never address a non-existent entry.
  logic [ADDR_W-1:0] sel_vaddr;
  logic [ADDR_W-1:0] sel_paddr;
  logic              sel_port;
  logic              sel_en;
  logic              cfg_idx_ok;
  logic              scan_hit;
  logic              scan_last;
  logic              cfg_gc;

  assign cfg_wr_ready = (state_q == IDLE) && !lk_req;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;
  assign lk_done      = lk_done_q;
  assign lk_hit       = lk_hit_q;
  assign lk_paddr     = lk_paddr_q;
  assign lk_port      = lk_port_q;
  assign cfg_err      = cfg_err_q;

  always_comb begin
    sel_vaddr  = '0;
    sel_paddr  = '0;
    sel_port   = 1'b0;
    sel_en     = 1'b0;
    cfg_idx_ok = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        sel_vaddr = tbl_vaddr_q[i];
        sel_paddr = tbl_paddr_q[i];
        sel_port  = tbl_port_q[i];
        sel_en    = tbl_en_q[i];
      end
      if (cfg_idx == IDX_W'(i)) begin
        cfg_idx_ok = 1'b1;
      end
    end
  end

  assign scan_hit  = sel_en && (sel_vaddr == lk_vaddr);
  assign scan_last = (scan_idx_q == IDX_W'(ENTRIES - 1));
  // Address 0x00 is the I2C general call; it can never be a valid mapping.
  assign cfg_gc    = (cfg_vaddr == '0);

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    lk_done_d  = 1'b0;
    lk_hit_d   = lk_hit_q;
    lk_paddr_d = lk_paddr_q;
    lk_port_d  = lk_port_q;
    cfg_err_d  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      tbl_vaddr_d[i] = tbl_vaddr_q[i];
      tbl_paddr_d[i] = tbl_paddr_q[i];
      tbl_port_d[i]  = tbl_port_q[i];
      tbl_en_d[i]    = tbl_en_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (lk_req) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end else if (cfg_wr_valid && cfg_wr_ready) begin
          cfg_err_d = !cfg_idx_ok || cfg_gc;
          for (int i = 0; i < ENTRIES; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              tbl_vaddr_d[i] = cfg_vaddr;
              tbl_paddr_d[i] = cfg_paddr;
              tbl_port_d[i]  = cfg_port;
              tbl_en_d[i]    = cfg_en && !cfg_gc;
            end
          end
        end
      end

      SCAN: begin
        // Scanning upward and stopping at the first match gives the lowest
        // index priority among duplicate virtual addresses.
        if (scan_hit || scan_last) begin
          state_d    = DONE;
          lk_done_d  = 1'b1;
          lk_hit_d   = scan_hit;
          lk_paddr_d = scan_hit ? sel_paddr : '0;
          lk_port_d  = scan_hit ? sel_port : 1'b0;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        // lk_req is still high here (requester drops it on lk_done), so it
        // is deliberately ignored to avoid a second lookup.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SCL or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      lk_done_q  <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_paddr_q <= '0;
      lk_port_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_vaddr_q[i] <= (i == 0) ? ADDR_W'(8'h21) :
                          (i == 1) ? ADDR_W'(8'h22) : '0;
        tbl_paddr_q[i] <= (i < 2) ? ADDR_W'(8'h48) : '0;
        tbl_port_q[i]  <= (i == 1);
        tbl_en_q[i]    <= (i < 2);
      end
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      lk_done_q  <= lk_done_d;
      lk_hit_q   <= lk_hit_d;
      lk_paddr_q <= lk_paddr_d;
      lk_port_q  <= lk_port_d;
      cfg_err_q  <= cfg_err_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_vaddr_q[i] <= tbl_vaddr_d[i];
        tbl_paddr_q[i] <= tbl_paddr_d[i];
        tbl_port_q[i]  <= tbl_port_d[i];
        tbl_en_q[i]    <= tbl_en_d[i];
      end
    end
  end

endmodule

// File: tb/tb_i2c_xlate_map_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_xlate_map_ctrl
//
// Directed bench for the address translator map controller. Built with
// IDX_W=3 so that out-of-range entry indices can be presented.
// Inputs change #1 after a rising edge; outputs are observed at that point.
// ---------------------------------------------------------------------------
module tb_i2c_xlate_map_ctrl;

  localparam int ENTRIES = 4;
  localparam int IDX_W   = 3;
  localparam int ADDR_W  = 7;

  logic              SCL;
  logic              rst_n;
  logic              lk_req;
  logic [ADDR_W-1:0] lk_vaddr;
  logic              lk_done;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_paddr;
  logic              lk_port;
  logic              cfg_wr_valid;
  logic              cfg_wr_ready;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_vaddr;
  logic [ADDR_W-1:0] cfg_paddr;
  logic              cfg_port;
  logic              cfg_en;
  logic              cfg_err;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  i2c_xlate_map_ctrl #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .SCL         (SCL),
    .rst_n       (rst_n),
    .lk_req      (lk_req),
    .lk_vaddr    (lk_vaddr),
    .lk_done     (lk_done),
    .lk_hit      (lk_hit),
    .lk_paddr    (lk_paddr),
    .lk_port     (lk_port),
    .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_ready(cfg_wr_ready),
    .cfg_idx     (cfg_idx),
    .cfg_vaddr   (cfg_vaddr),
    .cfg_paddr   (cfg_paddr),
    .cfg_port    (cfg_port),
    .cfg_en      (cfg_en),
    .cfg_err     (cfg_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial SCL = 1'b0;
  always #5 SCL = ~SCL;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge SCL);
    #1;
  endtask

  // Waits for lk_done; lat counts edges after the edge that sampled lk_req.
  // A timeout leaves lat at -1, which fails the caller's latency check.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lk_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_lookup(input string tag, input logic [ADDR_W-1:0] va, input int exp_lat,
                           input logic exp_hit, input logic [ADDR_W-1:0] exp_pa,
                           input logic exp_port);
    int lat;
    lk_vaddr = va;
    lk_req   = 1'b1;
    wait_done(lat);
    check({tag, "_lat"},   32'(lat),  32'(exp_lat));
    check({tag, "_hit"},   32'(lk_hit),   32'(exp_hit));
    check({tag, "_paddr"}, 32'(lk_paddr), 32'(exp_pa));
    check({tag, "_port"},  32'(lk_port),  32'(exp_port));
    lk_req = 1'b0;
    step();
    check({tag, "_done_one_cycle"}, 32'(lk_done), 32'd0);
    check({tag, "_idle_after"},     32'(busy),    32'd0);
  endtask

  task automatic do_write(input string tag, input logic [IDX_W-1:0] idx,
                          input logic [ADDR_W-1:0] va, input logic [ADDR_W-1:0] pa,
                          input logic port, input logic en, input logic exp_err);
    cfg_idx      = idx;
    cfg_vaddr    = va;
    cfg_paddr    = pa;
    cfg_port     = port;
    cfg_en       = en;
    cfg_wr_valid = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(cfg_wr_ready), 32'd1);
    step();
    cfg_wr_valid = 1'b0;
    check({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    step();
    check({tag, "_err_clear"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n        = 1'b0;
    lk_req       = 1'b0;
    lk_vaddr     = '0;
    cfg_wr_valid = 1'b0;
    cfg_idx      = '0;
    cfg_vaddr    = '0;
    cfg_paddr    = '0;
    cfg_port     = 1'b0;
    cfg_en       = 1'b0;

    // Reset state
    step();
    step();
    check("rst_done",  32'(lk_done),  32'd0);
    check("rst_hit",   32'(lk_hit),   32'd0);
    check("rst_paddr", 32'(lk_paddr), 32'd0);
    check("rst_port",  32'(lk_port),  32'd0);
    check("rst_err",   32'(cfg_err),  32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", 32'(cfg_wr_ready), 32'd1);

    // 1: default table
    do_lookup("def21", 7'h21, 1, 1'b1, 7'h48, 1'b0);
    do_lookup("def22", 7'h22, 2, 1'b1, 7'h48, 1'b1);

    // 2: miss; hit/paddr/port must drop back to zero
    do_lookup("miss50", 7'h50, 4, 1'b0, 7'h00, 1'b0);

    // 3: program last entry, then duplicate vaddr of entry0 in it
    do_write("wr3a", 3'd3, 7'h30, 7'h4A, 1'b1, 1'b1, 1'b0);
    do_lookup("hit30", 7'h30, 4, 1'b1, 7'h4A, 1'b1);
    do_write("wr3b", 3'd3, 7'h21, 7'h4A, 1'b1, 1'b1, 1'b0);
    do_lookup("prio21", 7'h21, 1, 1'b1, 7'h48, 1'b0);

    // 4: lookup and write in the same IDLE cycle; lookup sees old table
    lk_vaddr     = 7'h30;
    lk_req       = 1'b1;
    cfg_idx      = 3'd3;
    cfg_vaddr    = 7'h30;
    cfg_paddr    = 7'h33;
    cfg_port     = 1'b0;
    cfg_en       = 1'b1;
    cfg_wr_valid = 1'b1;
    #1;
    check("arb_ready_req", 32'(cfg_wr_ready), 32'd0);
    step();
    check("arb_busy",       32'(busy),         32'd1);
    check("arb_state_scan", 32'(dbg_state),    32'd1);
    check("arb_ready_scan", 32'(cfg_wr_ready), 32'd0);
    lat = -1;
    for (int i = 1; i < 30; i++) begin
      step();
      if (lk_done) begin
        lat = i;
        break;
      end
    end
    check("arb_lat",   32'(lat),    32'd4);
    check("arb_hit",   32'(lk_hit), 32'd0);
    check("arb_paddr", 32'(lk_paddr), 32'd0);
    lk_req = 1'b0;
    #1;
    check("arb_ready_done", 32'(cfg_wr_ready), 32'd0);
    step();
    check("arb_ready_idle", 32'(cfg_wr_ready), 32'd1);
    step();
    cfg_wr_valid = 1'b0;
    check("arb_wr_err", 32'(cfg_err), 32'd0);
    step();
    do_lookup("arb_new30", 7'h30, 4, 1'b1, 7'h33, 1'b0);

    // 5: general-call vaddr and out-of-range index
    do_write("wr_gc", 3'd2, 7'h00, 7'h10, 1'b0, 1'b1, 1'b1);
    do_lookup("gc00", 7'h00, 4, 1'b0, 7'h00, 1'b0);
    do_write("wr_oor", 3'd5, 7'h55, 7'h7F, 1'b1, 1'b1, 1'b1);
    do_lookup("oor55", 7'h55, 4, 1'b0, 7'h00, 1'b0);
    do_lookup("oor30", 7'h30, 4, 1'b1, 7'h33, 1'b0);

    // 6: reset during a scan after reprogramming entry0
    do_write("wr0", 3'd0, 7'h21, 7'h10, 1'b1, 1'b1, 1'b0);
    do_lookup("new21", 7'h21, 1, 1'b1, 7'h10, 1'b1);
    lk_vaddr = 7'h50;
    lk_req   = 1'b1;
    step();
    step();
    step();
    check("mid_state_scan", 32'(dbg_state), 32'd1);
    rst_n  = 1'b0;
    lk_req = 1'b0;
    #1;
    check("mid_rst_hit",   32'(lk_hit),   32'd0);
    check("mid_rst_paddr", 32'(lk_paddr), 32'd0);
    check("mid_rst_port",  32'(lk_port),  32'd0);
    check("mid_rst_busy",  32'(busy),     32'd0);
    step();
    check("mid_rst_done0", 32'(lk_done), 32'd0);
    step();
    check("mid_rst_done1", 32'(lk_done), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_done", 32'(lk_done), 32'd0);
    do_lookup("post21", 7'h21, 1, 1'b1, 7'h48, 1'b0);
    do_lookup("post30", 7'h30, 4, 1'b0, 7'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
